// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, compare-flag and width constants shared by the alu
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_IMMW  = 8;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_OR     = 4'd2,
    OP_XOR    = 4'd3,
    OP_AND    = 4'd4,
    OP_NOT    = 4'd5,
    OP_LDADDR = 4'd6,
    OP_STADDR = 4'd7,
    OP_LOADI  = 4'd8,
    OP_CMP    = 4'd9,
    OP_SHL    = 4'd10,
    OP_SHR    = 4'd11,
    OP_JUMPA  = 4'd12,
    OP_JUMPC  = 4'd13,
    OP_JUMPI  = 4'd14,
    OP_NOP    = 4'd15
  } opcode_e;

  // Bit positions of the CMP result flags
  localparam int CMP_EQ = 15;
  localparam int CMP_GT = 14;
  localparam int CMP_LT = 13;
  localparam int CMP_AZ = 12;
  localparam int CMP_BZ = 11;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - execute-stage alu with registered result and branch-taken flag
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int IMMW  = ALU_IMMW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [IMMW-1:0]  imm,
  output logic [WIDTH-1:0] dataResult,
  output logic             shldBranch
);

  localparam int SHW = $clog2(WIDTH);

  opcode_e          op;
  logic             f;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] addr_off;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] next_result;
  logic             next_branch;

  assign op    = opcode_e'(aluop[4:1]);
  assign f     = aluop[0];
  assign shamt = dataB[SHW-1:0];

  // Address ops only use the low five immediate bits as a signed offset
  assign addr_off = {{(WIDTH-5){imm[4]}}, imm[4:0]};
  assign imm_sext = {{(WIDTH-IMMW){imm[IMMW-1]}}, imm};

  always_comb begin
    next_result = '0;
    next_branch = 1'b0;
    unique case (op)
      OP_ADD:    next_result = dataA + dataB;
      OP_SUB:    next_result = dataA - dataB;
      OP_OR:     next_result = dataA | dataB;
      OP_XOR:    next_result = dataA ^ dataB;
      OP_AND:    next_result = dataA & dataB;
      OP_NOT:    next_result = ~dataA;
      OP_LDADDR,
      OP_STADDR: next_result = dataA + addr_off;
      OP_LOADI: begin
        if (f)
          next_result = {{(WIDTH-IMMW){1'b0}}, imm};
        else
          next_result = {imm, {(WIDTH-IMMW){1'b0}}};
      end
      OP_CMP: begin
        next_result[CMP_EQ] = (dataA == dataB);
        if (f) begin
          next_result[CMP_GT] = ($signed(dataA) > $signed(dataB));
          next_result[CMP_LT] = ($signed(dataA) < $signed(dataB));
        end else begin
          next_result[CMP_GT] = (dataA > dataB);
          next_result[CMP_LT] = (dataA < dataB);
        end
        next_result[CMP_AZ] = (dataA == '0);
        next_result[CMP_BZ] = (dataB == '0);
      end
      OP_SHL:    next_result = dataA << shamt;
      OP_SHR: begin
        if (f)
          next_result = $unsigned($signed(dataA) >>> shamt);
        else
          next_result = dataA >> shamt;
      end
      OP_JUMPA: begin
        next_result = dataA;
        next_branch = 1'b1;
      end
      OP_JUMPC: begin
        next_result = dataB;
        next_branch = f ? (dataA != '0) : (dataA == '0);
      end
      OP_JUMPI: begin
        next_result = imm_sext;
        next_branch = 1'b1;
      end
      OP_NOP: begin
        next_result = '0;
        next_branch = 1'b0;
      end
      default: begin
        next_result = '0;
        next_branch = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataResult <= '0;
      shldBranch <= 1'b0;
    end else if (en) begin
      dataResult <= next_result;
      shldBranch <= next_branch;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for the alu
module tb_alu;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  aluop;
  logic [15:0] dataA;
  logic [15:0] dataB;
  logic [7:0]  imm;
  logic [15:0] dataResult;
  logic        shldBranch;

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(16), .IMMW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .aluop      (aluop),
    .dataA      (dataA),
    .dataB      (dataB),
    .imm        (imm),
    .dataResult (dataResult),
    .shldBranch (shldBranch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Apply one operation, clock it in and sample just after the edge
  task automatic step(input logic [3:0] op, input logic f, input logic [15:0] a,
                      input logic [15:0] b, input logic [7:0] im);
    aluop = {op, f};
    dataA = a;
    dataB = b;
    imm   = im;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    aluop = '0;
    dataA = '0;
    dataB = '0;
    imm   = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset_result", dataResult, 16'h0000);
    chk("reset_branch", {15'd0, shldBranch}, 16'h0000);

    en = 1'b1;
    step(4'd0, 1'b0, 16'hFFFF, 16'h0002, 8'h00);
    chk("reset_priority_over_en", dataResult, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    step(4'd0, 1'b0, 16'hFFFF, 16'h0002, 8'h00);
    chk("add_wrap", dataResult, 16'h0001);
    chk("add_branch", {15'd0, shldBranch}, 16'h0000);
    step(4'd0, 1'b1, 16'h0003, 16'h0004, 8'h00);
    chk("add_f1", dataResult, 16'h0007);
    step(4'd1, 1'b0, 16'h0000, 16'h0001, 8'h00);
    chk("sub_wrap", dataResult, 16'hFFFF);
    step(4'd2, 1'b0, 16'h00F0, 16'h0F00, 8'h00);
    chk("or", dataResult, 16'h0FF0);
    step(4'd3, 1'b0, 16'h1234, 16'h00FF, 8'h00);
    chk("xor", dataResult, 16'h12CB);
    step(4'd4, 1'b0, 16'hF0F0, 16'hFF00, 8'h00);
    chk("and", dataResult, 16'hF000);
    step(4'd5, 1'b0, 16'h1234, 16'h0000, 8'h00);
    chk("not", dataResult, 16'hEDCB);
    step(4'd6, 1'b0, 16'h0100, 16'h0000, 8'h1F);
    chk("ldaddr_neg", dataResult, 16'h00FF);
    step(4'd7, 1'b0, 16'h0100, 16'h0000, 8'hE5);
    chk("staddr_pos", dataResult, 16'h0105);
    step(4'd8, 1'b0, 16'h0000, 16'h0000, 8'hA5);
    chk("loadi_f0", dataResult, 16'hA500);
    step(4'd8, 1'b1, 16'h0000, 16'h0000, 8'hA5);
    chk("loadi_f1", dataResult, 16'h00A5);
    step(4'd9, 1'b0, 16'h8000, 16'h0001, 8'h00);
    chk("cmp_unsigned", dataResult, 16'h4000);
    step(4'd9, 1'b1, 16'h8000, 16'h0001, 8'h00);
    chk("cmp_signed", dataResult, 16'h2000);
    step(4'd9, 1'b0, 16'h0000, 16'h0000, 8'h00);
    chk("cmp_zero", dataResult, 16'h9800);
    step(4'd10, 1'b0, 16'h0001, 16'h0013, 8'h00);
    chk("shl", dataResult, 16'h0008);
    step(4'd11, 1'b1, 16'h8000, 16'h0004, 8'h00);
    chk("shr_arith", dataResult, 16'hF800);
    step(4'd11, 1'b0, 16'h8000, 16'h0004, 8'h00);
    chk("shr_logic", dataResult, 16'h0800);

    step(4'd13, 1'b0, 16'h0000, 16'h0040, 8'h00);
    chk("jumpc_f0_taken_result", dataResult, 16'h0040);
    chk("jumpc_f0_taken_branch", {15'd0, shldBranch}, 16'h0001);
    step(4'd13, 1'b0, 16'h0001, 16'h0040, 8'h00);
    chk("jumpc_f0_not_taken", {15'd0, shldBranch}, 16'h0000);
    step(4'd13, 1'b1, 16'h0001, 16'h0080, 8'h00);
    chk("jumpc_f1_taken", {15'd0, shldBranch}, 16'h0001);
    step(4'd15, 1'b0, 16'h1111, 16'h2222, 8'h33);
    chk("nop_result", dataResult, 16'h0000);
    chk("nop_clears_branch", {15'd0, shldBranch}, 16'h0000);
    step(4'd14, 1'b0, 16'h0000, 16'h0000, 8'hF0);
    chk("jumpi_result", dataResult, 16'hFFF0);
    chk("jumpi_branch", {15'd0, shldBranch}, 16'h0001);
    step(4'd12, 1'b0, 16'h1234, 16'h0000, 8'h00);
    chk("jumpa_result", dataResult, 16'h1234);
    chk("jumpa_branch", {15'd0, shldBranch}, 16'h0001);
    en = 1'b0;
    step(4'd0, 1'b0, 16'h0001, 16'h0001, 8'h00);
    chk("hold_branch", {15'd0, shldBranch}, 16'h0001);
    en = 1'b1;

    step(4'd1, 1'b0, 16'h0005, 16'h0007, 8'h00);
    chk("sub_5_7", dataResult, 16'hFFFE);
    chk("sub_clears_branch", {15'd0, shldBranch}, 16'h0000);
    en = 1'b0;
    step(4'd0, 1'b0, 16'h0001, 16'h0001, 8'h00);
    chk("hold_result", dataResult, 16'hFFFE);

    en = 1'b1;
    step(4'd12, 1'b0, 16'h4321, 16'h0000, 8'h00);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_result", dataResult, 16'h0000);
    chk("async_reset_branch", {15'd0, shldBranch}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step(4'd0, 1'b0, 16'h0002, 16'h0003, 8'h00);
    chk("first_after_reset", dataResult, 16'h0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
